// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART IO constants: FSM states, bit counter codes, line levels, divider defaults
package uart_rx_pkg;

    // Byte-bus width towards the UART register logic
    localparam int BYTE_W = 8;

    // Default divider: 50 MHz system clock / 115200 baud
    localparam int UART_DIV_RATE = 434;

    // Bit counter: 0..7 select data bits, plus START and STOP codes
    localparam int UART_BIT_CNT_W = 4;
    localparam logic [UART_BIT_CNT_W-1:0] UART_BIT_START = 4'hF;
    localparam logic [UART_BIT_CNT_W-1:0] UART_BIT_MSB   = 4'd7;
    localparam logic [UART_BIT_CNT_W-1:0] UART_BIT_STOP  = 4'd8;

    // Line levels of the framing bits
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic {
        UART_STATE_IDLE = 1'b0,
        UART_STATE_RX   = 1'b1
    } uart_state_e;

    // Divider counter width for a given bit rate: ceil(log2(rate))
    function automatic int uart_div_cnt_w(input int rate);
        return (rate <= 2) ? 1 : $clog2(rate);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchronizer for the asynchronous rx line, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values simply shift the line through the two stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Both stages reset to 1 so a reset never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling; stop-bit check enabled by UART_RX_FRAME_ERR_EN
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DIV_RATE = UART_DIV_RATE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              rx_busy,
    output logic              rx_end,
    output logic [BYTE_W-1:0] rx_data,
    output logic              frame_err
);

    localparam int DIV_W = uart_div_cnt_w(DIV_RATE);
    // First sample lands mid start bit, later ones one full bit apart
    localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(DIV_RATE / 2 - 1);
    localparam logic [DIV_W-1:0] FULL_LOAD = DIV_W'(DIV_RATE - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    uart_state_e               state_q, state_d;
    logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
    logic [UART_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]         sh_reg_q, sh_reg_d;
    logic [BYTE_W-1:0]         rx_data_q, rx_data_d;
    logic                      rx_end_q, rx_end_d;
    logic                      frame_err_q, frame_err_d;

    // Frame sequencing: wait for start, count down to each bit centre, shift data LSB first
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sh_reg_d    = sh_reg_q;
        rx_data_d   = rx_data_q;
        rx_end_d    = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            UART_STATE_IDLE: begin
                if (rx_s == UART_START_BIT) begin
                    state_d   = UART_STATE_RX;
                    bit_cnt_d = UART_BIT_START;
                    div_cnt_d = HALF_LOAD;
                end
            end
            UART_STATE_RX: begin
                if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - DIV_W'(1);
                end else begin
                    div_cnt_d = FULL_LOAD;
                    if (bit_cnt_q == UART_BIT_START) begin
                        // Line back high at the start-bit centre: it was a glitch
                        if (rx_s == UART_STOP_BIT) begin
                            state_d = UART_STATE_IDLE;
                        end else begin
                            bit_cnt_d = '0;
                        end
                    end else if (bit_cnt_q == UART_BIT_STOP) begin
                        state_d   = UART_STATE_IDLE;
                        rx_data_d = sh_reg_q;
                        rx_end_d  = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                        frame_err_d = (rx_s == UART_START_BIT);
`endif
                    end else begin
                        sh_reg_d  = {rx_s, sh_reg_q[BYTE_W-1:1]};
                        bit_cnt_d = (bit_cnt_q == UART_BIT_MSB) ? UART_BIT_STOP
                                                                : bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = UART_STATE_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= UART_STATE_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= UART_BIT_START;
            sh_reg_q    <= '0;
            rx_data_q   <= '0;
            rx_end_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_reg_q    <= sh_reg_d;
            rx_data_q   <= rx_data_d;
            rx_end_q    <= rx_end_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_busy   = (state_q == UART_STATE_RX);
    assign rx_end    = rx_end_q;
    assign rx_data   = rx_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: directed frames, vector table and random frames vs a byte-level model
module tb_uart_rx;

    localparam int DIV = 16;
`ifdef UART_RX_FRAME_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_busy;
    logic       rx_end;
    logic [7:0] rx_data;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_rx #(.DIV_RATE(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_busy   (rx_busy),
        .rx_end    (rx_end),
        .rx_data   (rx_data),
        .frame_err (frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_cycles = 0;
    int stray_fe = 0;
    int end_cyc = 0;
    logic [8:0] cap_q[$];
    logic [8:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every completed byte as {frame_err, rx_data}
    always @(negedge clk) begin
        if (rx_busy === 1'b1) busy_cycles++;
        if (rx_end === 1'b1) begin
            cap_q.push_back({frame_err, rx_data});
            end_cyc = cyc;
        end
        if (frame_err === 1'b1 && rx_end !== 1'b1) stray_fe++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line-level stimulus: start, 8 data bits LSB first, one stop bit, then idle high
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(DIV);
        end
        rx = stop;
        tick(DIV);
        rx = 1'b1;
    endtask

    // Byte-level model: every well-started frame yields its byte; a low stop flags an error
    task automatic expect_frame(input logic [7:0] d, input logic stop);
        exp_q.push_back({(stop == 1'b0) && FE_EN, d});
    endtask

    task automatic compare_all(input string tag);
        logic [8:0] e;
        logic [8:0] a;
        tick(2 * DIV);
        check($sformatf("%s_count", tag), cap_q.size(), exp_q.size());
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            a = (cap_q.size() > 0) ? cap_q.pop_front() : 9'bx;
            check($sformatf("%s_frame%0d", tag, k), {23'd0, a}, {23'd0, e});
        end
        cap_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle_bits;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int st;
        logic [7:0] rb;
        logic       rs;
        int         gap;

        vecs[0] = '{8'hA5, 1'b1, 0};
        vecs[1] = '{8'h00, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 0};
        vecs[3] = '{8'h3C, 1'b0, 2};
        vecs[4] = '{8'h55, 1'b1, 0};
        vecs[5] = '{8'h81, 1'b1, 1};

        // Reset with idle line
        reset = 1'b1;
        rx    = 1'b1;
        tick(3);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_end", {31'd0, rx_end}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        busy_cycles = 0;
        tick(1000);
        check("idle_busy", busy_cycles, 0);
        check("idle_noend", cap_q.size(), 0);

        // Single frame 0xA5: latency and busy length
        busy_cycles = 0;
        st = cyc;
        send_frame(8'hA5, 1'b1);
        expect_frame(8'hA5, 1'b1);
        tick(DIV);
        lat = end_cyc - st;
        check("a5_latency_ok", {31'd0, (lat >= 155 && lat <= 157)}, 32'd1);
        check("a5_busy_ok", {31'd0, (busy_cycles >= 150 && busy_cycles <= 156)}, 32'd1);
        compare_all("a5");

        // Short low glitch: busy blips, no byte
        busy_cycles = 0;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * DIV);
        check("glitch_busy", {31'd0, (busy_cycles > 0 && busy_cycles < DIV)}, 32'd1);
        check("glitch_idle", {31'd0, rx_busy}, 32'd0);
        compare_all("glitch");

        // Reset after data bit 3 of a frame, then a clean 0x81
        rb = 8'h5A;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            tick(DIV);
        end
        reset = 1'b1;
        tick(2);
        check("midrst_busy", {31'd0, rx_busy}, 32'd0);
        check("midrst_data", {24'd0, rx_data}, 32'd0);
        rx = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2 * DIV);
        send_frame(8'h81, 1'b1);
        expect_frame(8'h81, 1'b1);
        compare_all("midrst");

        // Vector table, back-to-back where idle_bits is 0
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].stop);
            expect_frame(vecs[v].data, vecs[v].stop);
            tick(vecs[v].idle_bits * DIV);
        end
        compare_all("table");

        // Random frames; a bad stop bit is followed by at least one idle bit
        for (int r = 0; r < 12; r++) begin
            rb  = 8'($urandom);
            rs  = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 2);
            if (!rs && gap == 0) gap = 1;
            send_frame(rb, rs);
            expect_frame(rb, rs);
            tick(gap * DIV);
        end
        compare_all("rand");

        check("stray_frame_err", stray_fe, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
